// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard-FSM state encodings and register-number width.
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_LDUSE = 2'd1,
    HZ_FLUSH = 2'd2,
    HZ_ILL   = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard bus: ID/EX hazard inputs in, pipeline-steering controls out.
// Counter signals exist only when HAZARD_STATS_EN is defined.
interface hazard_ctrl_if;
  import pipe_pkg::*;

  logic [REG_W-1:0] id_Ra;
  logic [REG_W-1:0] id_Rb;
  logic             id_useRb;
  logic [REG_W-1:0] ex_Rw;
  logic             ex_RegWr;
  logic             ex_MemtoReg;
  logic             redirect;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             hazard;
  logic [1:0]       state_o;
`ifdef HAZARD_STATS_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;
`endif

  // Pipeline side: presents ID/EX fields, consumes steering controls.
  modport master (
    output id_Ra, id_Rb, id_useRb, ex_Rw, ex_RegWr, ex_MemtoReg, redirect,
    input  pc_stall, if_id_stall, if_id_flush, hazard, state_o
`ifdef HAZARD_STATS_EN
    , input stall_cnt, flush_cnt
`endif
  );

  // Controller side.
  modport slave (
    input  id_Ra, id_Rb, id_useRb, ex_Rw, ex_RegWr, ex_MemtoReg, redirect,
    output pc_stall, if_id_stall, if_id_flush, hazard, state_o
`ifdef HAZARD_STATS_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/hz_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Registered: value reflects events up to the previous clock edge.
module hz_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and redirect squash sequencer for the 5-stage pipeline; outputs are Mealy.
// Optional stall/flush event counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  hazard_ctrl_if.slave  hz
);

  // fcnt holds the squash cycles still owed after the current one.
  localparam logic [1:0] FCNT_LOAD   = 2'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

  hz_state_e  state_q;
  hz_state_e  state_d;
  logic [1:0] fcnt_q;
  logic [1:0] fcnt_d;

  logic lu;
  logic pc_stall_c;
  logic if_id_stall_c;
  logic if_id_flush_c;
  logic hazard_c;

  always_comb begin
    lu = hz.ex_RegWr && hz.ex_MemtoReg && (hz.ex_Rw != '0) &&
         ((hz.ex_Rw == hz.id_Ra) || (hz.id_useRb && (hz.ex_Rw == hz.id_Rb)));
  end

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    pc_stall_c    = 1'b0;
    if_id_stall_c = 1'b0;
    if_id_flush_c = 1'b0;
    hazard_c      = 1'b0;

    unique case (state_q)
      // LDUSE is the post-bubble cycle; it reacts to new events exactly like RUN.
      HZ_RUN, HZ_LDUSE: begin
        if (hz.redirect) begin
          if_id_flush_c = 1'b1;
          hazard_c      = 1'b1;
          fcnt_d        = FCNT_LOAD;
          state_d       = MULTI_FLUSH ? HZ_FLUSH : HZ_RUN;
        end else if (lu) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          hazard_c      = 1'b1;
          state_d       = HZ_LDUSE;
        end else begin
          state_d       = HZ_RUN;
        end
      end

      // Wrong-path instruction in ID: load-use is irrelevant here.
      HZ_FLUSH: begin
        if_id_flush_c = 1'b1;
        hazard_c      = 1'b1;
        if (hz.redirect) begin
          fcnt_d  = FCNT_LOAD;
          state_d = MULTI_FLUSH ? HZ_FLUSH : HZ_RUN;
        end else if (fcnt_q <= 2'd1) begin
          fcnt_d  = 2'd0;
          state_d = HZ_RUN;
        end else begin
          fcnt_d  = fcnt_q - 2'd1;
        end
      end

      default: begin
        fcnt_d  = 2'd0;
        state_d = HZ_RUN;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= HZ_RUN;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Reset gates the Mealy paths so an asynchronous reset silences outputs at once.
  assign hz.pc_stall    = pc_stall_c    & ~Reset;
  assign hz.if_id_stall = if_id_stall_c & ~Reset;
  assign hz.if_id_flush = if_id_flush_c & ~Reset;
  assign hz.hazard      = hazard_c      & ~Reset;
  assign hz.state_o     = state_q;

`ifdef HAZARD_STATS_EN
  hz_sat_counter #(.W(32)) u_stall_cnt (
    .clk (Clk),
    .rst (Reset),
    .inc (hz.pc_stall),
    .cnt (hz.stall_cnt)
  );

  hz_sat_counter #(.W(32)) u_flush_cnt (
    .clk (Clk),
    .rst (Reset),
    .inc (hz.if_id_flush),
    .cnt (hz.flush_cnt)
  );
`endif

  a_no_stall_with_flush : assert property (
    @(posedge Clk) disable iff (Reset) !(hz.if_id_flush && (hz.pc_stall || hz.if_id_stall))
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (FLUSH_CYCLES=3): directed scenarios plus random traffic.
module tb_hazard_ctrl;

  localparam int FC = 3;

  typedef struct packed {
    logic [5:0]  o;    // {pc_stall, if_id_stall, if_id_flush, hazard, state[1:0]}
    logic [31:0] sc;
    logic [31:0] fc;
    logic [31:0] tag;
  } exp_t;

  logic Clk;
  logic Reset;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .hz    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] cyc = 0;

  // Reference model: squash cycles still owed, whether last cycle stalled, event totals.
  int          m_squash = 0;
  bit          m_stalled = 0;
  logic [31:0] m_sc = 0;
  logic [31:0] m_fc = 0;

  task automatic step(input logic [4:0] ra, input logic [4:0] rb, input logic userb,
                      input logic [4:0] rw, input logic regwr, input logic memtoreg,
                      input logic redir, input logic rst);
    exp_t e;
    bit   lu;
    bit   st, fl;
    bus.id_Ra       = ra;
    bus.id_Rb       = rb;
    bus.id_useRb    = userb;
    bus.ex_Rw       = rw;
    bus.ex_RegWr    = regwr;
    bus.ex_MemtoReg = memtoreg;
    bus.redirect    = redir;
    Reset           = rst;

    lu = regwr && memtoreg && (rw != 0) && ((rw == ra) || (userb && (rw == rb)));
    st = 0;
    fl = 0;
    e.tag = cyc;
    if (rst) begin
      e.o = 6'b0;
      e.sc = 0;
      e.fc = 0;
      m_squash = 0;
      m_stalled = 0;
      m_sc = 0;
      m_fc = 0;
    end else begin
      e.sc = m_sc;
      e.fc = m_fc;
      e.o[1:0] = (m_squash > 0) ? 2'd2 : (m_stalled ? 2'd1 : 2'd0);
      if (redir || m_squash > 0) begin
        fl = 1;
        m_squash = redir ? FC - 1 : m_squash - 1;
      end else if (lu) begin
        st = 1;
      end
      m_stalled = st;
      e.o[5:2] = {st, st, fl, st | fl};
      if (st && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (fl && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    end
    q.push_back(e);
    @(posedge Clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the head of the queue.
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e = q.pop_front();
      act = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.hazard, bus.state_o};
      n_checks++;
      if (act !== e.o) begin
        n_fail++;
        $display("FAIL outs cyc=%0d got=%b want=%b (stall,ifid_stall,flush,hazard,state)",
                 e.tag, act, e.o);
      end
`ifdef HAZARD_STATS_EN
      n_checks++;
      if (bus.stall_cnt !== e.sc) begin
        n_fail++;
        $display("FAIL stall_cnt cyc=%0d got=%h want=%h", e.tag, bus.stall_cnt, e.sc);
      end
      n_checks++;
      if (bus.flush_cnt !== e.fc) begin
        n_fail++;
        $display("FAIL flush_cnt cyc=%0d got=%h want=%h", e.tag, bus.flush_cnt, e.fc);
      end
`endif
    end
  end

  initial begin
    Reset = 1'b1;
    bus.id_Ra = 0; bus.id_Rb = 0; bus.id_useRb = 0; bus.ex_Rw = 0;
    bus.ex_RegWr = 0; bus.ex_MemtoReg = 0; bus.redirect = 0;
    @(posedge Clk);
    #1;

    // Reset holds outputs low even with a load-use and redirect pending.
    step(5, 5, 1, 5, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Load-use on Ra, then idle: state 0 -> 1 -> 0.
    step(5, 0, 0, 5, 1, 1, 0, 0);
    idle(2);

    // Rb gating.
    step(3, 5, 0, 5, 1, 1, 0, 0);
    step(3, 5, 1, 5, 1, 1, 0, 0);
    idle(2);

    // r0 never stalls.
    step(0, 0, 1, 0, 1, 1, 0, 0);
    // Back-to-back load chain stalls twice.
    step(7, 0, 0, 7, 1, 1, 0, 0);
    step(9, 0, 0, 9, 1, 1, 0, 0);
    idle(2);

    // Redirect: 3 squash cycles, with a load-use in ID ignored during the window.
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(4, 0, 0, 4, 1, 1, 0, 0);
    idle(3);

    // Redirect together with load-use: flush only.
    step(6, 0, 0, 6, 1, 1, 1, 0);
    idle(4);

    // Second redirect in the 2nd squash cycle extends the window to 4.
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(5);

    // Asynchronous reset during the 2nd squash cycle.
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // Random traffic over a small register set so dependencies are common.
    for (int i = 0; i < 3000; i++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 199) == 0));
    end
    idle(4);

`ifdef HAZARD_STATS_EN
    // Saturation: preload the stall counter just below all-ones.
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.cnt_q;
    m_sc = 32'hFFFF_FFFE;
    idle(1);
    for (int i = 0; i < 3; i++) begin
      step(8, 0, 0, 8, 1, 1, 0, 0);
      idle(1);
    end
`endif

    // Drain, bounded.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Drives the `hazard` bubble input of the ID/EX register, the PC and IF/ID stall/flush controls, and sequences load-use stalls and taken-branch/jump squash windows. Sits beside the decode stage: it reads ID-stage source registers, the EX-stage control fields and the branch/jump resolution, and returns the pipeline-steering signals consumed by the PC, IF/ID and ID/EX registers.

## Interface
- `FLUSH_CYCLES`, default 1: number of cycles wrong-path instructions are squashed after a redirect; legal range 1–3.
- `Clk`  input  1  pipeline clock; all state updates on the rising edge.
- `Reset`  input  1  asynchronous, active-high reset.
- `id_Ra`, `id_Rb`  input  5 each  ID-stage source register numbers.
- `id_useRb`  input  1  the ID instruction reads `id_Rb`; 0 for I-type ALU ops, loads and jumps.
- `ex_Rw`  input  5  EX-stage destination register.
- `ex_RegWr`, `ex_MemtoReg`  input  1 each  EX-stage control; both high means a load is in EX.
- `redirect`  input  1  taken branch or jump resolved this cycle.
- `pc_stall`  output  1  hold the PC.
- `if_id_stall`  output  1  hold IF/ID.
- `if_id_flush`  output  1  zero IF/ID (turn it into a nop).
- `hazard`  output  1  insert a bubble into ID/EX.
- `state_o`  output  2  current FSM state, for debug.
- `stall_cnt`, `flush_cnt`  output  32 each  event counters; present only with `HAZARD_STATS_EN`.

## Operation
- Load-use detect `lu` = `ex_RegWr & ex_MemtoReg & (ex_Rw != 0) & ((ex_Rw == id_Ra) | (id_useRb & ex_Rw == id_Rb))`.
- States: `RUN` (2'd0), `LDUSE` (2'd1), `FLUSH` (2'd2). 2'd3 is illegal and next cycle goes to `RUN` with all outputs 0.
- `RUN`:
  - `redirect` → `if_id_flush=1`, `hazard=1`; load `fcnt = FLUSH_CYCLES-1`; go to `FLUSH` if `FLUSH_CYCLES > 1`, otherwise stay in `RUN`.
  - else `lu` → `pc_stall=1`, `if_id_stall=1`, `hazard=1`; go to `LDUSE`.
  - else all outputs 0.
- `LDUSE`: lasts exactly one cycle with outputs 0, because the bubble has cleared the dependency. Next state is `RUN`.
  - `redirect` here is handled as in `RUN` (flush).
  - `lu` here (a back-to-back load chain) stalls again and stays in `LDUSE`.
- `FLUSH`: `if_id_flush=1`, `hazard=1`, stalls 0; decrement `fcnt`; go to `RUN` when `fcnt == 0`.
  - `redirect` in `FLUSH` reloads `fcnt = FLUSH_CYCLES-1`.
  - `lu` is ignored in `FLUSH`, since the instruction in ID is wrong-path.
- Priority: `redirect` > `lu`. The stall outputs and `if_id_flush` are never asserted together.
- `fcnt` is 2 bits wide.

## Timing
- All outputs are combinational from the registered state plus the current inputs (Mealy), so they are valid in the same cycle the condition appears. ID/EX samples `hazard` at the following edge.
- Load-use costs exactly 1 bubble cycle. A redirect costs `FLUSH_CYCLES` bubble cycles.
- Reset values: state `RUN`, `fcnt` 0, counters 0. With `Reset` high, all outputs are 0 regardless of the inputs.
- `Reset` asserted mid-`FLUSH` or mid-`LDUSE` aborts the sequence immediately. After release the controller is in `RUN`.
- `ex_Rw == 0` never stalls.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stall_cnt` increments on every cycle with `pc_stall=1`.
  - `flush_cnt` increments on every cycle with `if_id_flush=1`.
  - Both are 32-bit, saturate at 32'hFFFFFFFF and clear on `Reset`.
- `HAZARD_STATS_EN` undefined: the counter ports and logic are absent.

## Structure
- Shared package `pipe_pkg`: state encodings `HZ_RUN`, `HZ_LDUSE`, `HZ_FLUSH`, and the 5-bit register-number width.
- One sub-module, `hz_sat_counter` (32-bit saturating counter), instantiated twice, only under `HAZARD_STATS_EN`.
- Detect logic and FSM stay in `hazard_ctrl`.

## Test plan
- Load-use on Ra: `ex_RegWr=1`, `ex_MemtoReg=1`, `ex_Rw=5`, `id_Ra=5` → `pc_stall=1`, `if_id_stall=1`, `hazard=1` for 1 cycle; `state_o` 0→1→0; with stats enabled, `stall_cnt=1`.
- Rb-gated: same as above but `id_Rb=5`, `id_Ra=3`; `id_useRb=0` gives no stall, `id_useRb=1` gives a 1-cycle stall. `ex_Rw=0` with `id_Ra=0` never stalls.
- Redirect with `FLUSH_CYCLES=3`: pulse `redirect` → `if_id_flush=1` and `hazard=1` for 3 consecutive cycles, then 0; `flush_cnt=3`.
- Simultaneous events: `redirect=1` together with `lu=1` → flush outputs only, `pc_stall=0`. A second `redirect` in the 2nd `FLUSH` cycle extends the squash to 4 cycles total.
- Reset mid-operation: assert `Reset` asynchronously during the 2nd `FLUSH` cycle → outputs 0 immediately, `state_o=0`, counters 0.
- Stats build: force `stall_cnt` near 32'hFFFFFFFF, apply 2 stalls → counter holds 32'hFFFFFFFF.
